// File: rtl/scandoubler_vid_writer.sv
// Capture-side writer for the scandoubler SDRAM video-write port: packs pixels into
// aligned 8-word bursts in a ping-pong buffer and presents them on the vidin_* port.
module scandoubler_vid_writer #(
   parameter logic [15:0] PAD_VALUE = 16'h0000
) (
   input  logic        clk_96,
   input  logic        reset,
   input  logic        pix_ce,
   input  logic [15:0] pix_d,
   input  logic        hs,
   input  logic        vs,
   output logic        vidin_req,
   output logic [1:0]  vidin_frame,
   output logic [10:0] vidin_row,
   output logic [10:0] vidin_col,
   output logic [15:0] vidin_d,
   input  logic        vidin_ack,
   output logic [1:0]  done_frame,
   output logic        overflow
);

   localparam int unsigned DW = 16;
   localparam int unsigned XW = 11;
   localparam int unsigned YW = 11;
   localparam int unsigned FW = 2;
   localparam int unsigned IW = 3;
   localparam int unsigned BW = XW - IW;
   localparam int unsigned WORDS = 2 << IW;
   localparam logic [IW-1:0] LAST_IDX = '1;

   typedef enum logic {
      S_IDLE,
      S_BURST
   } state_t;

   state_t state, state_nxt;

   logic [DW-1:0] mem [WORDS];
   logic [1:0]    full;
   logic [FW-1:0] half_frame [2];
   logic [YW-1:0] half_row   [2];
   logic [BW-1:0] half_base  [2];

   logic          wr_half;
   logic [IW-1:0] wr_idx;
   logic [XW-1:0] x_cnt;
   logic [YW-1:0] y_cnt;
   logic [FW-1:0] frame_cnt;

   logic          rd_half;
   logic [IW-1:0] rd_idx;

   logic          hs_q, hs_qq, vs_q, vs_qq;
   logic          pend_valid;
   logic [DW-1:0] pend_d;

   logic          hs_rise_c, vs_rise_c, line_evt_c;
   logic          src_valid_c;
   logic [DW-1:0] src_d_c;
   logic          do_pix_c, half_full_c, store_c, drop_c, pend_lost_c;
   logic          flush_c, complete_c;
   logic          burst_start_c, burst_done_c, word_adv_c;
   logic [IW-1:0] rd_nxt_c;

   // Sync edge detection: one register stage plus the previous-level register.
   always_ff @(posedge clk_96) begin
      if (reset) begin
         hs_q  <= 1'b0;
         hs_qq <= 1'b0;
         vs_q  <= 1'b0;
         vs_qq <= 1'b0;
      end else begin
         hs_q  <= hs;
         hs_qq <= hs_q;
         vs_q  <= vs;
         vs_qq <= vs_q;
      end
   end

   assign hs_rise_c  = hs_q & ~hs_qq;
   assign vs_rise_c  = vs_q & ~vs_qq;
   assign line_evt_c = hs_rise_c | vs_rise_c;

   // A pixel arriving in a flush cycle waits one cycle in the pending slot.
   assign src_valid_c = pend_valid | pix_ce;
   assign src_d_c     = pend_valid ? pend_d : pix_d;
   assign do_pix_c    = src_valid_c & ~line_evt_c;
   assign pend_lost_c = line_evt_c & pend_valid & pix_ce;

   // A half freed by the reader this cycle is writable in the same cycle.
   assign half_full_c = full[wr_half] & ~(burst_done_c & (rd_half == wr_half));
   assign store_c     = do_pix_c & ~half_full_c;
   assign drop_c      = do_pix_c & half_full_c;
   assign flush_c     = line_evt_c & (wr_idx != '0);
   assign complete_c  = flush_c | (store_c & (wr_idx == LAST_IDX));

   always_ff @(posedge clk_96) begin
      if (reset) begin
         pend_valid <= 1'b0;
         pend_d     <= '0;
      end else if (line_evt_c && src_valid_c) begin
         pend_valid <= 1'b1;
         pend_d     <= src_d_c;
      end else if (pend_valid && pix_ce) begin
         pend_valid <= 1'b1;
         pend_d     <= pix_d;
      end else begin
         pend_valid <= 1'b0;
      end
   end

   // Pixel storage; a flush pads every word from wr_idx to the end of the half.
   always_ff @(posedge clk_96) begin
      if (flush_c) begin
         for (int i = 0; i < (1 << IW); i++) begin
            if (IW'(i) >= wr_idx) mem[{wr_half, IW'(i)}] <= PAD_VALUE;
         end
      end else if (store_c) begin
         mem[{wr_half, wr_idx}] <= src_d_c;
      end
   end

   // Fill pointer, position counters, full flags and per-half tags.
   always_ff @(posedge clk_96) begin
      if (reset) begin
         full       <= '0;
         wr_half    <= 1'b0;
         wr_idx     <= '0;
         x_cnt      <= '0;
         y_cnt      <= '0;
         frame_cnt  <= '0;
         done_frame <= '1;
         overflow   <= 1'b0;
         for (int h = 0; h < 2; h++) begin
            half_frame[h] <= '0;
            half_row[h]   <= '0;
            half_base[h]  <= '0;
         end
      end else begin
         if (burst_done_c) full[rd_half] <= 1'b0;
         if (drop_c || pend_lost_c) overflow <= 1'b1;
         if (complete_c) begin
            full[wr_half]       <= 1'b1;
            half_frame[wr_half] <= frame_cnt;
            half_row[wr_half]   <= y_cnt;
            half_base[wr_half]  <= x_cnt[XW-1:IW];
            wr_half             <= ~wr_half;
         end
         if (line_evt_c) begin
            wr_idx <= '0;
            x_cnt  <= '0;
            if (vs_rise_c) begin
               done_frame <= frame_cnt;
               frame_cnt  <= frame_cnt + FW'(1);
               y_cnt      <= '0;
            end else begin
               y_cnt <= y_cnt + YW'(1);
            end
         end else if (store_c) begin
            wr_idx <= wr_idx + IW'(1);
            x_cnt  <= x_cnt + XW'(1);
         end
      end
   end

   // Output FSM: state register.
   always_ff @(posedge clk_96) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // Output FSM: next state.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (full[rd_half]) state_nxt = S_BURST;
         S_BURST: if (vidin_ack && (rd_idx == LAST_IDX)) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Output FSM: per-state control strobes.
   always_comb begin
      burst_start_c = 1'b0;
      burst_done_c  = 1'b0;
      word_adv_c    = 1'b0;
      case (state)
         S_IDLE:  burst_start_c = full[rd_half];
         S_BURST: begin
            if (vidin_ack) begin
               burst_done_c = (rd_idx == LAST_IDX);
               word_adv_c   = (rd_idx != LAST_IDX);
            end
         end
         default: ;
      endcase
   end

   assign rd_nxt_c = rd_idx + IW'(1);

   // Registered vidin_* presentation; one word advance per ack.
   always_ff @(posedge clk_96) begin
      if (reset) begin
         rd_half     <= 1'b0;
         rd_idx      <= '0;
         vidin_req   <= 1'b0;
         vidin_frame <= '0;
         vidin_row   <= '0;
         vidin_col   <= '0;
         vidin_d     <= '0;
      end else begin
         if (burst_start_c) begin
            rd_idx      <= '0;
            vidin_req   <= 1'b1;
            vidin_frame <= half_frame[rd_half];
            vidin_row   <= half_row[rd_half];
            vidin_col   <= {half_base[rd_half], IW'(0)};
            vidin_d     <= mem[{rd_half, IW'(0)}];
         end
         if (word_adv_c) begin
            rd_idx    <= rd_nxt_c;
            vidin_col <= {half_base[rd_half], rd_nxt_c};
            vidin_d   <= mem[{rd_half, rd_nxt_c}];
         end
         if (burst_done_c) begin
            vidin_req <= 1'b0;
            rd_half   <= ~rd_half;
         end
      end
   end

endmodule

// File: tb/tb_scandoubler_vid_writer.sv
// Bench for scandoubler_vid_writer: a line/frame level pixel model predicts every burst,
// and an acking controller agent checks each presented word against it.
module tb_scandoubler_vid_writer;

   localparam logic [15:0] PAD = 16'hDEAD;

   logic        clk_96 = 1'b0;
   logic        reset, pix_ce, hs, vs, vidin_ack;
   logic [15:0] pix_d;
   logic        vidin_req, overflow;
   logic [1:0]  vidin_frame, done_frame;
   logic [10:0] vidin_row, vidin_col;
   logic [15:0] vidin_d;

   scandoubler_vid_writer #(.PAD_VALUE(PAD)) dut (
      .clk_96(clk_96), .reset(reset), .pix_ce(pix_ce), .pix_d(pix_d), .hs(hs), .vs(vs),
      .vidin_req(vidin_req), .vidin_frame(vidin_frame), .vidin_row(vidin_row),
      .vidin_col(vidin_col), .vidin_d(vidin_d), .vidin_ack(vidin_ack),
      .done_frame(done_frame), .overflow(overflow)
   );

   always #5 clk_96 = ~clk_96;

   typedef struct packed {
      logic [1:0]        fr;
      logic [10:0]       row;
      logic [7:0]        base;
      logic [7:0][15:0]  w;
   } burst_t;

   burst_t      exp_q[$];
   burst_t      cur;
   int          cur_n, pending, word_i;
   logic [10:0] m_x, m_row;
   logic [1:0]  m_frame, m_done;
   logic        m_ovf;
   bit          ack_en, ack_rand;
   int          n_cmp = 0, n_bad = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      exp_q.delete();
      cur = '0; cur_n = 0; pending = 0; word_i = 0;
      m_x = '0; m_row = '0; m_frame = '0; m_done = 2'd3; m_ovf = 1'b0;
   endtask

   task automatic model_push();
      cur.fr  = m_frame;
      cur.row = m_row;
      exp_q.push_back(cur);
      cur_n = 0;
      pending++;
   endtask

   // A pixel is lost only while two completed bursts are still undelivered.
   task automatic model_pix(input logic [15:0] d);
      if (pending == 2) begin
         m_ovf = 1'b1;
         return;
      end
      if (cur_n == 0) cur.base = m_x[10:3];
      cur.w[cur_n] = d;
      m_x = m_x + 11'd1;
      cur_n++;
      if (cur_n == 8) model_push();
   endtask

   task automatic take_word();
      burst_t b;
      if (exp_q.size() == 0) begin
         check_eq("spurious_req", 32'(vidin_req), 32'd0);
         return;
      end
      b = exp_q[0];
      check_eq("frame", 32'(vidin_frame), 32'(b.fr));
      check_eq("row",   32'(vidin_row),   32'(b.row));
      check_eq("col",   32'(vidin_col),   32'({b.base, 3'(word_i)}));
      check_eq("data",  32'(vidin_d),     32'(b.w[word_i]));
      word_i++;
      if (word_i == 8) begin
         void'(exp_q.pop_front());
         word_i = 0;
         pending--;
      end
   endtask

   // One clock: drive on the falling edge, let the agent ack, update the model.
   task automatic step(input bit p, input logic [15:0] d, input bit r);
      @(negedge clk_96);
      pix_ce = p;
      pix_d  = d;
      reset  = r;
      vidin_ack = ack_en && vidin_req && !r && (!ack_rand || $urandom_range(0, 2) != 0);
      if (vidin_ack) take_word();
      if (p && !r) model_pix(d);
      @(posedge clk_96);
      #1;
      pix_ce = 1'b0;
      vidin_ack = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 16'h0, 1'b0);
   endtask

   task automatic feed(input int n, input int gap, input int start, input bit rnd);
      for (int i = 0; i < n; i++) begin
         step(1'b1, rnd ? 16'($urandom) : 16'(start + i), 1'b0);
         idle(gap - 1);
      end
   endtask

   // Raise hs and/or vs, with the model taking the line/frame step at the raise.
   task automatic sync_edge(input bit h, input bit v);
      if (cur_n != 0) begin
         for (int k = cur_n; k < 8; k++) cur.w[k] = PAD;
         model_push();
      end
      m_x = '0;
      if (v) begin
         m_done  = m_frame;
         m_frame = m_frame + 2'd1;
         m_row   = '0;
      end else begin
         m_row = m_row + 11'd1;
      end
      hs = h; vs = v;
      idle(3);
      hs = 1'b0; vs = 1'b0;
      idle(3);
      if (v) check_eq("done_frame", 32'(done_frame), 32'(m_done));
   endtask

   task automatic drain(input int budget);
      ack_en = 1'b1;
      for (int i = 0; i < budget && exp_q.size() != 0; i++) idle(1);
      idle(3);
      check_eq("undelivered_bursts", 32'(exp_q.size()), 32'd0);
      check_eq("req_after_drain", 32'(vidin_req), 32'd0);
   endtask

   initial begin
      reset = 1'b1; pix_ce = 1'b0; pix_d = '0; hs = 1'b0; vs = 1'b0; vidin_ack = 1'b0;
      ack_en = 1'b0; ack_rand = 1'b0;
      model_reset();
      step(1'b0, 16'h0, 1'b1);
      step(1'b0, 16'h0, 1'b1);
      check_eq("rst_req",   32'(vidin_req),   32'd0);
      check_eq("rst_frame", 32'(vidin_frame), 32'd0);
      check_eq("rst_row",   32'(vidin_row),   32'd0);
      check_eq("rst_col",   32'(vidin_col),   32'd0);
      check_eq("rst_d",     32'(vidin_d),     32'd0);
      check_eq("rst_done",  32'(done_frame),  32'd3);
      check_eq("rst_ovf",   32'(overflow),    32'd0);

      // Two full bursts at 1/4 rate, prompt acks.
      ack_en = 1'b1;
      feed(16, 4, 0, 1'b0);
      drain(100);
      check_eq("ovf_basic", 32'(overflow), 32'd0);

      // Partial line padded at hs, next line starts at row 1 col 0.
      sync_edge(1'b1, 1'b0);
      feed(11, 4, 0, 1'b0);
      sync_edge(1'b1, 1'b0);
      feed(8, 4, 16'h100, 1'b0);
      sync_edge(1'b1, 1'b0);
      feed(5, 4, 16'h200, 1'b0);
      sync_edge(1'b0, 1'b1);
      feed(8, 4, 16'h300, 1'b0);
      drain(100);

      // Three more frame steps wrap the frame counter.
      for (int f = 0; f < 3; f++) begin
         feed(8, 3, 16'h400 + 16 * f, 1'b0);
         sync_edge(1'b0, 1'b1);
      end
      feed(8, 3, 16'h500, 1'b0);
      drain(100);

      // Randomised traffic with random ack spacing.
      ack_rand = 1'b1;
      for (int i = 0; i < 300; i++) begin
         int r;
         r = int'($urandom_range(0, 149));
         if (r < 4)      sync_edge(1'b1, 1'b0);
         else if (r < 5) sync_edge(1'b0, 1'b1);
         else            feed(1, int'($urandom_range(4, 6)), 0, 1'b1);
      end
      drain(200);
      check_eq("ovf_random", 32'(overflow), 32'(m_ovf));
      ack_rand = 1'b0;

      // Coincident hs+vs with 4 pixels pending: one flush, then the frame step.
      feed(4, 4, 16'h600, 1'b0);
      sync_edge(1'b1, 1'b1);
      feed(8, 4, 16'h700, 1'b0);
      drain(100);

      // Ack withheld: 24 pixels, the last 8 are dropped.
      sync_edge(1'b1, 1'b0);
      ack_en = 1'b0;
      feed(24, 3, 0, 1'b0);
      check_eq("ovf_set", 32'(overflow), 32'(m_ovf));
      check_eq("ovf_model", 32'(m_ovf), 32'd1);
      drain(100);
      check_eq("ovf_sticky", 32'(overflow), 32'd1);

      // Reset after the third ack of a burst.
      ack_en = 1'b0;
      feed(8, 3, 16'h800, 1'b0);
      idle(2);
      ack_en = 1'b1;
      for (int i = 0; i < 20 && word_i < 3; i++) idle(1);
      check_eq("acks_before_reset", 32'(word_i), 32'd3);
      ack_en = 1'b0;
      step(1'b0, 16'h0, 1'b1);
      check_eq("mid_rst_req",  32'(vidin_req),  32'd0);
      check_eq("mid_rst_col",  32'(vidin_col),  32'd0);
      check_eq("mid_rst_ovf",  32'(overflow),   32'd0);
      check_eq("mid_rst_done", 32'(done_frame), 32'd3);
      model_reset();
      idle(2);
      ack_en = 1'b1;
      feed(8, 3, 16'h900, 1'b0);
      drain(100);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/scandoubler_vid_writer.md
# scandoubler_vid_writer

Capture-side client of the scandoubler SDRAM controller's video-write port. It accepts incoming pixels on a clock enable and packs them into aligned 8-word bursts in a 16-word ping-pong buffer. It then drives the `vidin_*` request interface, advancing one word per `vidin_ack`. It maintains the frame, row and column counters that form the SDRAM tile address, and publishes the last completed frame index to the read side.

## Interface
- `PAD_VALUE`, default 16'h0000: fill word for a partial burst at end of line.
- `clk_96` in 1: system clock; the SDRAM controller runs on the same clock.
- `reset` in 1: synchronous, active-high, sampled on `clk_96`.
- `pix_ce` in 1: one-cycle strobe; the pixel on `pix_d` is valid.
- `pix_d` in 16: incoming pixel word.
- `hs` in 1: horizontal sync level, synchronous to `clk_96`; the rising edge ends the line.
- `vs` in 1: vertical sync level, synchronous to `clk_96`; the rising edge ends the frame.
- `vidin_req` out 1: burst pending; held high until the 8th ack.
- `vidin_frame` out 2: frame of the current burst.
- `vidin_row` out 11: line (y) of the current burst.
- `vidin_col` out 11: word x of the word currently presented.
- `vidin_d` out 16: word currently presented.
- `vidin_ack` in 1: the controller consumed the presented word.
- `done_frame` out 2: index of the last fully written frame.
- `overflow` out 1: sticky; a pixel was dropped because both halves were full.

## Operation
- Buffer: two 8-word halves H0/H1, each with a full flag, a latched frame, a latched row and a base x (`base[10:3]`, low 3 bits 0).
- Fill pointer: `wr_half` and `wr_idx` (3 bits).
- Counters: `x_cnt` (11 bits), `y_cnt` (11 bits), `frame_cnt` (2 bits).
- Pixel write (`pix_ce` while the target half is not full):
  - Store at [`wr_half`][`wr_idx`], then increment `x_cnt` and `wr_idx`.
  - On `wr_idx`==7: mark the half full, latch `frame_cnt`/`y_cnt`/`base`=`x_cnt`[10:3], and toggle `wr_half`.
- Pixel while the target half is full: drop the pixel, set `overflow`, and do not advance `x_cnt`.
- `hs` rising edge:
  - If `wr_idx`≠0, the half is completed with `PAD_VALUE` in the remaining words, marked full, and `wr_half` toggles.
  - Then `x_cnt`=0, `wr_idx`=0 and `y_cnt` increments (wraps at 2047).
- `vs` rising edge:
  - Does the `hs` flush first if one is needed.
  - Then `done_frame`=`frame_cnt`, `frame_cnt` increments (wraps 3→0), and `y_cnt`=0, `x_cnt`=0.
  - If `hs` and `vs` edges coincide, one flush happens, followed by the frame step.
- Output FSM, states IDLE and BURST:
  - IDLE: if the half `rd_half` is full, go to BURST, set `rd_idx`=0 and assert `vidin_req`.
  - BURST: `vidin_d`=word[`rd_half`][`rd_idx`] and `vidin_col`={`base`, `rd_idx`}. `vidin_frame`/`vidin_row` come from the half's latched values.
  - BURST, on each `vidin_ack`: `rd_idx` increments.
  - BURST, on the 8th ack (`rd_idx`==7): deassert `vidin_req`, clear the full flag, toggle `rd_half` and return to IDLE.
- Bursts are never split. The 8 words always share `vidin_frame`, `vidin_row` and `vidin_col[10:3]`.
- Freeing a half and filling it in the same cycle: the clear applies first, then the write proceeds, so no drop occurs.
- `reset` values:
  - Outputs: `vidin_req`=0, `vidin_frame`=0, `vidin_row`=0, `vidin_col`=0, `vidin_d`=0, `done_frame`=3, `overflow`=0.
  - Internal: all counters and full flags 0; FSM in IDLE.
- `reset` mid-burst: `vidin_req` drops at the next edge and buffered data is discarded.

## Timing
- Registered outputs only.
- `vidin_req` rises 1 cycle after the fill that completes a half; a pad flush counts as that fill.
- `vidin_d`/`vidin_col` update on the edge after each ack and are stable while ack is low. `vidin_ack` may arrive on consecutive cycles.
- `vidin_req` is low on the edge after the 8th ack. This is required so the controller does not re-issue a write at its next STATE_FIRST.
- IDLE→BURST for a second full half takes 1 cycle, so back-to-back bursts have at least 1 low cycle of `vidin_req`.
- `hs`/`vs` edge detection adds 1 cycle; the pad flush completes within 8 cycles of the edge (1 word/cycle), and `pix_ce` during the flush is held off by buffering at most 1 pixel.
- Throughput: 8 words per ~16 controller cycles, which sustains `pix_ce` at 1/3 rate or lower.

## Test plan
- Reset, then 16 pixels 0x0000..0x000F at `pix_ce`=1/4 rate, ack 1 cycle after each `vidin_req`/word change:
  - burst 1 carries cols 0..7 with data 0..7; burst 2 carries cols 8..15 with data 8..15.
  - `vidin_frame`=0, `vidin_row`=0, `overflow`=0.
- 11 pixels then `hs` rising:
  - second burst cols 8..15 carries data 8,9,10 and then 5×`PAD_VALUE`.
  - `vidin_row`=0 for that burst; the next line's burst shows `vidin_row`=1, col 0.
- `vs` rising after 3 lines → `done_frame`=0 and the next burst has `vidin_frame`=1, `vidin_row`=0.
  - Four `vs` edges → `frame_cnt` wraps to 0.
- Ack held low, 24 pixels:
  - pixels 17..24 are dropped and `overflow`=1 (sticky).
  - After acks, exactly 16 words 0..15 are delivered.
- `reset` asserted after the 3rd ack of a burst:
  - next cycle `vidin_req`=0, `vidin_col`=0, `overflow`=0.
  - The next 8 pixels produce a fresh burst at col 0.
- Coincident `hs`+`vs` edge with 4 pixels pending:
  - one padded burst with the old frame/row.
  - Then `frame_cnt`+1, `y_cnt`=0.
